mod_mult_seq: RTL
=================

Name: mod_mult_seq

Overview:
- Sequential modular multiplier: computes product = (a * b) mod prime for WIDTH-bit unsigned operands.
- It is the forward-direction companion of the modular-inverse block. Feeding it a and its computed inverse must return 1, so the bench uses it as the checker for inverse results.
- Start/done handshake with fixed latency.
- Operands need not be pre-reduced. An internal reduce phase brings a and b below prime first.

Parameters:
- WIDTH, 8, operand, modulus and result width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- prime  input  WIDTH  modulus; latched on accepted start. Primality is not checked; any value >= 2 works.
- a  input  WIDTH  multiplicand; latched on accepted start.
- b  input  WIDTH  multiplier; latched on accepted start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when product/error are valid.
- product  output  WIDTH  result register; holds until the next completion.
- error  output  1  set on completion if latched prime < 2; holds until the next completion.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy=0, done=0, product=0, error=0; all internal registers cleared.
- Reset mid-operation aborts the operation with no partial result. Operation resumes only after rst_n=1 and a new start.

State IDLE:
- On a rising edge with start=1, latch prime, a and b into p_r, a_r and b_r. Clear error on acceptance.
- If prime < 2: go to DONE with product=0 and error=1.
- Otherwise go to REDUCE with bit counter=WIDTH-1 and both remainder registers (WIDTH+1 bits) = 0.

State REDUCE (exactly WIDTH cycles):
- Runs a restoring remainder in parallel for a_r and b_r, MSB first, one bit per cycle.
- Each cycle, per operand: r = (r << 1) | operand[cnt]; if r >= p_r then r = r - p_r.
- After the bit-0 step, ra = a mod p and rb = b mod p. Go to MULT with cnt reset to WIDTH-1 and acc=0.

State MULT (exactly WIDTH cycles):
- Interleaved MSB-first multiply of ra by the bits of rb.
- Each cycle: t = 2*acc + (rb[cnt] ? ra : 0). The WIDTH+2 bit intermediate covers the maximum 3p-3.
- Then conditionally subtract p once, and again if still >= p, giving acc < p.
- After the bit-0 step, go to DONE and register product = acc[WIDTH-1:0].

State DONE (one cycle):
- done=1; product and error are valid. Next edge goes to IDLE.

Latency and handshake:
- Start is accepted at edge E0. done=1 during the cycle after edge E0+2*WIDTH (16 edges for WIDTH=8). busy=1 from E0 through the DONE cycle.
- Error path: done=1 in the cycle after E0 (1-edge latency).
- start while busy=1 (including the DONE cycle) is ignored; no queueing. Operand inputs may change freely after acceptance.
- Back-to-back: start may be asserted in the first IDLE cycle after DONE.

Boundary and width rules:
- All comparisons and subtractions are unsigned.
- Zero operand gives product=0.
- prime = 2^WIDTH-1 must not overflow; intermediates are sized as stated above.
- a=0 and b=0 with valid prime gives product=0, error=0.

Test Plan:
- prime=5, a=3, b=2, start one cycle -> busy 1 for 17 cycles; done pulse exactly 16 edges after accept; product=1, error=0. Confirms 3 is the inverse of 2 mod 5.
- prime=13, a=11, b=6 -> product=1. Then prime=251, a=200, b=250 -> product=51. Then prime=255, a=254, b=254 -> product=1 (max-width, no overflow).
- Unreduced operands: prime=5, a=17, b=3 -> product=1. Also prime=7, a=0, b=200 -> product=0.
- Error path: prime=1, a=3, b=4 -> done 1 edge after accept; error=1, product=0. A following valid op with prime=5, a=3, b=4 -> error cleared, product=2.
- start re-pulsed mid-MULT with prime=13, a=11, b=6 while computing 3*2 mod 5 -> ignored; product=1, single done pulse.
- rst_n low for 1 cycle during REDUCE -> busy, done, product and error go to 0 immediately. No done pulse follows. A new start with prime=13, a=11, b=6 completes normally with product=1.

Source files
------------

// File: rtl/mod_mult_seq_if.sv
// Start/done handshake bundle for the sequential modular multiplier.
// The requester drives the operands and start; the multiplier drives status and result.
interface mod_mult_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] prime;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product;
   logic             error;

   modport master (
      output start, prime, a, b,
      input  busy, done, product, error
   );

   modport slave (
      input  start, prime, a, b,
      output busy, done, product, error
   );
endinterface

// File: rtl/mod_mult_seq.sv
// Sequential (a * b) mod prime: a WIDTH-cycle reduce phase brings both operands below
// prime, then a WIDTH-cycle MSB-first interleaved multiply keeps the accumulator below prime.
module mod_mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   mod_mult_seq_if.slave bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REDUCE = 2'd1;
   localparam logic [1:0] S_MULT   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] p_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH:0]   ra;
   logic [WIDTH:0]   rb;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] product_r;
   logic             error_r;

   logic [WIDTH:0]   ra_nxt;
   logic [WIDTH:0]   rb_nxt;
   logic [WIDTH-1:0] acc_nxt;

   // One restoring-remainder step: since r < p, 2r+bit < 2p, so one subtract suffices.
   function automatic logic [WIDTH:0] reduce_step(input logic [WIDTH:0]   r,
                                                  input logic             bit_in,
                                                  input logic [WIDTH-1:0] p);
      logic [WIDTH+1:0] t;
      t = {r, bit_in};
      if (t >= {2'b00, p})
         t = t - {2'b00, p};
      return t[WIDTH:0];
   endfunction

   // One interleaved multiply step: 2*acc + ra can reach 3p-3, so up to two subtracts.
   function automatic logic [WIDTH-1:0] mult_step(input logic [WIDTH-1:0] acc_in,
                                                  input logic             add_en,
                                                  input logic [WIDTH:0]   ra_in,
                                                  input logic [WIDTH-1:0] p);
      logic [WIDTH+1:0] t;
      t = {1'b0, acc_in, 1'b0} + (add_en ? {1'b0, ra_in} : '0);
      if (t >= {2'b00, p})
         t = t - {2'b00, p};
      if (t >= {2'b00, p})
         t = t - {2'b00, p};
      return t[WIDTH-1:0];
   endfunction

   assign ra_nxt  = reduce_step(ra, a_r[cnt], p_r);
   assign rb_nxt  = reduce_step(rb, b_r[cnt], p_r);
   assign acc_nxt = mult_step(acc, rb[cnt], ra, p_r);

   assign bus.busy    = (state != S_IDLE);
   assign bus.done    = (state == S_DONE);
   assign bus.product = product_r;
   assign bus.error   = error_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         p_r       <= '0;
         a_r       <= '0;
         b_r       <= '0;
         ra        <= '0;
         rb        <= '0;
         acc       <= '0;
         product_r <= '0;
         error_r   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  p_r <= bus.prime;
                  a_r <= bus.a;
                  b_r <= bus.b;
                  if (bus.prime < WIDTH'(2)) begin
                     product_r <= '0;
                     error_r   <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     error_r <= 1'b0;
                     cnt     <= CNT_W'(WIDTH - 1);
                     ra      <= '0;
                     rb      <= '0;
                     state   <= S_REDUCE;
                  end
               end
            end
            S_REDUCE: begin
               ra <= ra_nxt;
               rb <= rb_nxt;
               if (cnt == '0) begin
                  cnt   <= CNT_W'(WIDTH - 1);
                  acc   <= '0;
                  state <= S_MULT;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_MULT: begin
               acc <= acc_nxt;
               if (cnt == '0) begin
                  product_r <= acc_nxt;
                  state     <= S_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
